// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush/forwarding control for a 5-stage CPU.   |
// | Optional perf counters enabled by macro HAZ_PERF_CNT_EN.  Revision: 1.0    |
// +---------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int REG_W      = 5,
  parameter int MC_MAX_CYC = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic [REG_W-1:0] idex_rs1,
  input  logic [REG_W-1:0] idex_rs2,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_wr,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             memwb_wr,
  input  logic             br_taken,
  input  logic             mc_start,
  input  logic             mc_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WD_W    = (MC_MAX_CYC > 1) ? $clog2(MC_MAX_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_MAX_CYC - 1);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            mc_timeout_q, mc_timeout_d;
  logic            wd_expire;
  logic            mcs;
  logic            lu;

  // The expiring cycle releases the EX instruction exactly as mc_done would.
  assign wd_expire = (state_q == ST_MC_WAIT) && (wdog_q == WD_LAST);
  assign mcs       = mc_start && !mc_done && !wd_expire;
  assign lu        = idex_mem_read && (idex_rd != '0) &&
                     ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (exmem_wr && (exmem_rd != '0) && (exmem_rd == idex_rs1))      fwd_a = 2'b10;
      else if (memwb_wr && (memwb_rd != '0) && (memwb_rd == idex_rs1)) fwd_a = 2'b01;
      if (exmem_wr && (exmem_rd != '0) && (exmem_rd == idex_rs2))      fwd_b = 2'b10;
      else if (memwb_wr && (memwb_rd != '0) && (memwb_rd == idex_rs2)) fwd_b = 2'b01;
    end
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mcs) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    wdog_d       = '0;
    mc_timeout_d = mc_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (mc_start && !mc_done) state_d = ST_MC_WAIT;
      end
      ST_MC_WAIT: begin
        if (mc_done) begin
          state_d = ST_RUN;
        end else if (wd_expire) begin
          state_d      = ST_RUN;
          mc_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      wdog_q       <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign mc_timeout = mc_timeout_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // A load-use squashed by a taken branch is not a bubble, so it is not a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((mcs || (lu && !br_taken)) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_taken && !mcs && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: directed self-checking bench.  Revision: 1.0      |
// +---------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       idex_mem_read, exmem_wr, memwb_wr, br_taken, mc_start, mc_done;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, mc_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  logic [4:0] en_v;
  logic [2:0] fl_v;
  assign en_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  assign fl_v = {ifid_flush, idex_flush, exmem_flush};

  pipeline_hazard_ctrl #(.REG_W(5), .MC_MAX_CYC(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_mem_read(idex_mem_read),
    .exmem_rd(exmem_rd), .exmem_wr(exmem_wr),
    .memwb_rd(memwb_rd), .memwb_wr(memwb_wr),
    .br_taken(br_taken), .mc_start(mc_start), .mc_done(mc_done),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_timeout(mc_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifid_rs1 = '0; ifid_rs2 = '0; idex_rs1 = '0; idex_rs2 = '0; idex_rd = '0;
    exmem_rd = '0; memwb_rd = '0; idex_mem_read = 1'b0; exmem_wr = 1'b0;
    memwb_wr = 1'b0; br_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    // Forwarding inputs active during reset must still yield fwd = 00.
    exmem_wr = 1'b1; exmem_rd = 5'd5; idex_rs1 = 5'd5;
    #1;
    chk("rst_en",   32'(en_v), 32'h00);
    chk("rst_fl",   32'(fl_v), 32'h7);
    chk("rst_fwda", 32'(fwd_a), 32'h0);
    tick();
    chk("rst2_en", 32'(en_v), 32'h00);
    tick();
    chk("rst_tmo",   32'(mc_timeout), 32'h0);
    chk("rst_stall", stall_cnt, 32'h0);
    chk("rst_flush", flush_cnt, 32'h0);

    reset = 1'b0; idle(); #1;
    chk("idle_en",   32'(en_v), 32'h1F);
    chk("idle_fl",   32'(fl_v), 32'h0);
    chk("idle_fwdb", 32'(fwd_b), 32'h0);

    // Forwarding priority and register-0 exclusion
    exmem_wr = 1'b1; exmem_rd = 5'd5; memwb_wr = 1'b1; memwb_rd = 5'd5;
    idex_rs1 = 5'd5; idex_rs2 = 5'd5; #1;
    chk("fwda_exmem", 32'(fwd_a), 32'h2);
    chk("fwdb_exmem", 32'(fwd_b), 32'h2);
    exmem_wr = 1'b0; #1;
    chk("fwda_memwb", 32'(fwd_a), 32'h1);
    idex_rs2 = 5'd9; #1;
    chk("fwdb_nomatch", 32'(fwd_b), 32'h0);
    exmem_wr = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0; idex_rs1 = 5'd0; #1;
    chk("fwda_r0", 32'(fwd_a), 32'h0);
    idle(); exmem_wr = 1'b1; exmem_rd = 5'd3; memwb_wr = 1'b1; memwb_rd = 5'd9;
    idex_rs1 = 5'd9; idex_rs2 = 5'd3; #1;
    chk("fwda_split", 32'(fwd_a), 32'h1);
    chk("fwdb_split", 32'(fwd_b), 32'h2);
    tick();

    // Load-use: one bubble
    idle(); idex_mem_read = 1'b1; idex_rd = 5'd7; ifid_rs2 = 5'd7; #1;
    chk("lu_en", 32'(en_v), 32'h07);
    chk("lu_fl", 32'(fl_v), 32'h2);
    tick();
    chk("lu_stall", stall_cnt, PERF ? 32'd1 : 32'd0);
    idle(); #1;
    chk("lu_after_en", 32'(en_v), 32'h1F);
    idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; #1;
    chk("lu_r0_en", 32'(en_v), 32'h1F);
    tick();

    // Branch beats load-use
    idle(); idex_mem_read = 1'b1; idex_rd = 5'd7; ifid_rs2 = 5'd7; br_taken = 1'b1; #1;
    chk("br_en", 32'(en_v), 32'h1F);
    chk("br_fl", 32'(fl_v), 32'h6);
    tick();
    chk("br_flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
    chk("br_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);

    // Multi-cycle op, done on 4th cycle; branch held pending behind it
    idle(); mc_start = 1'b1; br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mc_en", 32'(en_v), 32'h03);
      chk("mc_fl", 32'(fl_v), 32'h1);
      tick();
    end
    mc_done = 1'b1; #1;
    chk("mc_done_en", 32'(en_v), 32'h1F);
    chk("mc_done_fl", 32'(fl_v), 32'h6);
    tick();
    idle(); #1;
    chk("mc_run_en", 32'(en_v), 32'h1F);
    chk("mc_stall_cnt", stall_cnt, PERF ? 32'd4 : 32'd0);
    chk("mc_flush_cnt", flush_cnt, PERF ? 32'd2 : 32'd0);
    mc_start = 1'b1; mc_done = 1'b1; #1;
    chk("mc_1cyc_en", 32'(en_v), 32'h1F);
    tick();

    // Watchdog timeout: 8 stall cycles, then release
    idle(); mc_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("wd_stall_en", 32'(en_v), 32'h03);
      chk("wd_tmo_low",  32'(mc_timeout), 32'h0);
      tick();
    end
    #1;
    chk("wd_release_en", 32'(en_v), 32'h1F);
    tick();
    idle(); #1;
    chk("wd_tmo_set", 32'(mc_timeout), 32'h1);
    chk("wd_stall_cnt", stall_cnt, PERF ? 32'd12 : 32'd0);
    tick();
    chk("wd_tmo_sticky", 32'(mc_timeout), 32'h1);

    // Reset on the second MC_WAIT cycle
    mc_start = 1'b1;
    tick();
    tick();
    reset = 1'b1; #1;
    chk("mcrst_en", 32'(en_v), 32'h00);
    tick();
    reset = 1'b0; idle(); #1;
    chk("mcrst_en_after", 32'(en_v), 32'h1F);
    chk("mcrst_tmo",      32'(mc_timeout), 32'h0);
    chk("mcrst_stall",    stall_cnt, 32'h0);
    chk("mcrst_flush",    flush_cnt, 32'h0);
    tick();
    chk("mcrst_en_next",  32'(en_v), 32'h1F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
